l2_port_arbiter: RTL

- Shares the single L2 cache request port between the L1 instruction-side (read-only) and L1 data-side (read/write) miss paths.
- Round-robin arbitration; latches the winning request, drives the L2 renable/wenable/addr/wdata port, waits out L2 cache_stall, returns the 512-bit block with a one-cycle ack.
- Watchdog flags an L2 transaction that never completes.

---
 rtl/l2_port_arbiter_if.sv | 33 +++
 rtl/l2_port_arbiter.sv | 131 +++++++++++++
 2 files changed

// File: rtl/l2_port_arbiter_if.sv
// rtl/l2_port_arbiter_if.sv - L1 I/D miss request and L2 port signal bundle
interface l2_port_arbiter_if;
    logic         i_req;
    logic [31:0]  i_addr;
    logic         i_ack;
    logic [511:0] i_rdata;
    logic         d_req;
    logic         d_we;
    logic [31:0]  d_addr;
    logic [31:0]  d_wdata;
    logic         d_ack;
    logic [511:0] d_rdata;
    logic         l2_renable;
    logic         l2_wenable;
    logic [31:0]  l2_addr;
    logic [31:0]  l2_wdata;
    logic         l2_stall;
    logic [511:0] l2_data;
    logic         busy;
    logic         timeout_err;

    modport slave (
        input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, l2_stall, l2_data,
        output i_ack, i_rdata, d_ack, d_rdata, l2_renable, l2_wenable,
               l2_addr, l2_wdata, busy, timeout_err
    );

    modport master (
        output i_req, i_addr, d_req, d_we, d_addr, d_wdata, l2_stall, l2_data,
        input  i_ack, i_rdata, d_ack, d_rdata, l2_renable, l2_wenable,
               l2_addr, l2_wdata, busy, timeout_err
    );
endinterface

// File: rtl/l2_port_arbiter.sv
// rtl/l2_port_arbiter.sv - round-robin arbiter sharing the L2 port between L1 I and D miss paths
module l2_port_arbiter #(
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    l2_port_arbiter_if.slave   bus
);
    typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT, ST_DONE} state_t;

    localparam logic [CNT_W-1:0] LP_CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_t             r_state;
    state_t             w_next;
    logic               w_sel_d;
    logic               w_timeout;

    logic               r_grant_d;
    logic               r_last_d;
    logic               r_we;
    logic [31:0]        r_addr;
    logic [31:0]        r_wdata;
    logic [CNT_W-1:0]   r_wait_cnt;

    logic               r_i_ack;
    logic               r_d_ack;
    logic [511:0]       r_i_rdata;
    logic [511:0]       r_d_rdata;
    logic               r_l2_renable;
    logic               r_l2_wenable;
    logic [31:0]        r_l2_addr;
    logic [31:0]        r_l2_wdata;
    logic               r_busy;
    logic               r_timeout_err;

    // On a tie the side that did not win last time is picked.
    assign w_sel_d   = bus.d_req & (~bus.i_req | ~r_last_d);
    assign w_timeout = (r_state == ST_WAIT) & bus.l2_stall & (r_wait_cnt == LP_CNT_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:  if (bus.i_req | bus.d_req) w_next = ST_ISSUE;
            ST_ISSUE: w_next = ST_WAIT;
            ST_WAIT:  if (!bus.l2_stall || w_timeout) w_next = ST_DONE;
            ST_DONE:  w_next = ST_IDLE;
            default:  w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_grant_d     <= 1'b0;
            r_last_d      <= 1'b1;
            r_we          <= 1'b0;
            r_addr        <= '0;
            r_wdata       <= '0;
            r_wait_cnt    <= '0;
            r_i_ack       <= 1'b0;
            r_d_ack       <= 1'b0;
            r_i_rdata     <= '0;
            r_d_rdata     <= '0;
            r_l2_renable  <= 1'b0;
            r_l2_wenable  <= 1'b0;
            r_l2_addr     <= '0;
            r_l2_wdata    <= '0;
            r_busy        <= 1'b0;
            r_timeout_err <= 1'b0;
        end else begin
            r_i_ack <= 1'b0;
            r_d_ack <= 1'b0;
            r_busy  <= (w_next != ST_IDLE);
            case (r_state)
                ST_IDLE: begin
                    if (bus.i_req | bus.d_req) begin
                        r_grant_d <= w_sel_d;
                        r_addr    <= w_sel_d ? bus.d_addr : bus.i_addr;
                        r_we      <= w_sel_d & bus.d_we;
                        r_wdata   <= w_sel_d ? bus.d_wdata : 32'h0;
                    end
                end
                ST_ISSUE: begin
                    r_l2_renable <= 1'b1;
                    r_l2_wenable <= r_we;
                    r_l2_addr    <= r_addr;
                    r_l2_wdata   <= r_wdata;
                    r_wait_cnt   <= '0;
                end
                ST_WAIT: begin
                    if (!bus.l2_stall) begin
                        if (!r_we) begin
                            if (r_grant_d) r_d_rdata <= bus.l2_data;
                            else           r_i_rdata <= bus.l2_data;
                        end
                    end else begin
                        r_wait_cnt <= r_wait_cnt + CNT_W'(1);
                        if (w_timeout) r_timeout_err <= 1'b1;
                    end
                end
                ST_DONE: begin
                    r_i_ack      <= ~r_grant_d;
                    r_d_ack      <= r_grant_d;
                    r_l2_renable <= 1'b0;
                    r_l2_wenable <= 1'b0;
                    r_last_d     <= r_grant_d;
                end
                default: ;
            endcase
        end
    end

    assign bus.i_ack       = r_i_ack;
    assign bus.d_ack       = r_d_ack;
    assign bus.i_rdata     = r_i_rdata;
    assign bus.d_rdata     = r_d_rdata;
    assign bus.l2_renable  = r_l2_renable;
    assign bus.l2_wenable  = r_l2_wenable;
    assign bus.l2_addr     = r_l2_addr;
    assign bus.l2_wdata    = r_l2_wdata;
    assign bus.busy        = r_busy;
    assign bus.timeout_err = r_timeout_err;
endmodule
